// File: rtl/idex_stage_reg.sv
// idex_stage_reg: ID->EX pipeline register, one instruction slot.
// Valid/ready handshake with stall, flush and operand bypass applied at capture.
// Optional feature: define IDEX_FWD_EN to enable EX/MEM and MEM/WB operand bypass.
// Without it, the *_fwd_* ports remain on the module but are ignored.
module idex_stage_reg #(
   parameter int XLEN       = 32,
   parameter int REG_IDX_W  = 5,
   parameter int ALU_TYPE_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  flush,
   input  logic [ALU_TYPE_W-1:0] alu_type_in,
   input  logic [REG_IDX_W-1:0]  rs1_in,
   input  logic [REG_IDX_W-1:0]  rs2_in,
   input  logic [REG_IDX_W-1:0]  rd_in,
   input  logic [XLEN-1:0]       src1_in,
   input  logic [XLEN-1:0]       src2_in,
   input  logic                  imm_tag,
   input  logic [XLEN-1:0]       imm,
   input  logic                  wr_tag_in,
   input  logic                  ex_fwd_we,
   input  logic [REG_IDX_W-1:0]  ex_fwd_rd,
   input  logic [XLEN-1:0]       ex_fwd_data,
   input  logic                  wb_fwd_we,
   input  logic [REG_IDX_W-1:0]  wb_fwd_rd,
   input  logic [XLEN-1:0]       wb_fwd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ALU_TYPE_W-1:0] alu_type,
   output logic [XLEN-1:0]       src1,
   output logic [XLEN-1:0]       src2_imm,
   output logic [REG_IDX_W-1:0]  rd,
   output logic                  wr_tag
);

   logic            capture;
   logic            consume;
   logic [XLEN-1:0] src1_sel;
   logic [XLEN-1:0] src2_sel;
   logic [XLEN-1:0] src2_imm_nxt;

   // The slot can take a new instruction when empty or when EX drains it this cycle.
   assign in_ready = !out_valid || out_ready;
   // A flush drops any instruction presented in the same cycle.
   assign capture  = in_valid && in_ready && !flush;
   assign consume  = out_valid && out_ready;

`ifdef IDEX_FWD_EN
   // Operand bypass: the younger EX/MEM result wins over MEM/WB; x0 is never bypassed.
   always_comb begin
      src1_sel = src1_in;
      src2_sel = src2_in;
      if (rs1_in != '0 && ex_fwd_we && ex_fwd_rd == rs1_in)
         src1_sel = ex_fwd_data;
      else if (rs1_in != '0 && wb_fwd_we && wb_fwd_rd == rs1_in)
         src1_sel = wb_fwd_data;
      if (rs2_in != '0 && ex_fwd_we && ex_fwd_rd == rs2_in)
         src2_sel = ex_fwd_data;
      else if (rs2_in != '0 && wb_fwd_we && wb_fwd_rd == rs2_in)
         src2_sel = wb_fwd_data;
   end
`else
   assign src1_sel = src1_in;
   assign src2_sel = src2_in;

   logic unused_fwd;
   assign unused_fwd = ^{rs1_in, rs2_in, ex_fwd_we, ex_fwd_rd, ex_fwd_data,
                         wb_fwd_we, wb_fwd_rd, wb_fwd_data};
`endif

   // The immediate replaces the second operand outright, so any rs2 bypass is ignored.
   assign src2_imm_nxt = imm_tag ? imm : src2_sel;

   // Slot occupancy and write-enable; flush and drain both leave a bubble that never writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         wr_tag    <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
         wr_tag    <= 1'b0;
      end else if (capture) begin
         out_valid <= 1'b1;
         wr_tag    <= wr_tag_in && (rd_in != '0);
      end else if (consume) begin
         out_valid <= 1'b0;
         wr_tag    <= 1'b0;
      end
   end

   // Payload loads only on capture; it holds through stall, drain and flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         alu_type <= '0;
         src1     <= '0;
         src2_imm <= '0;
         rd       <= '0;
      end else if (capture) begin
         alu_type <= alu_type_in;
         src1     <= src1_sel;
         src2_imm <= src2_imm_nxt;
         rd       <= rd_in;
      end
   end

endmodule
